// File: rtl/aclint_pkg.sv
// aclint_pkg: region offsets, response codes, address decode and byte-merge helpers for the ACLINT
package aclint_pkg;
    localparam logic [15:0] MSWI_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_OFF     = 16'hBFF8;
    localparam logic [15:0] SSWI_BASE     = 16'hC000;
    localparam logic [15:0] DIV_OFF       = 16'hD000;
    localparam logic [1:0]  AXI_OKAY      = 2'b00;
    localparam logic [1:0]  AXI_SLVERR    = 2'b10;

    typedef enum logic [2:0] {REG_NONE, REG_MSIP, REG_MTIMECMP, REG_MTIME, REG_SSIP, REG_DIV} region_e;

    // Regions are contiguous and ordered, so a chain of upper-bound compares decodes them.
    function automatic region_e region_of(input logic [15:0] off);
        return off[1:0] != 2'b00   ? REG_NONE :
               off < MTIMECMP_BASE ? REG_MSIP :
               off < MTIME_OFF     ? REG_MTIMECMP :
               off < SSWI_BASE     ? REG_MTIME :
               off < DIV_OFF       ? REG_SSIP :
               off == DIV_OFF      ? REG_DIV : REG_NONE;
    endfunction

    function automatic logic [12:0] hart_of(input logic [15:0] off, input region_e r);
        logic [15:0] d;
        d = off - (r == REG_MTIMECMP ? MTIMECMP_BASE : r == REG_SSIP ? SSWI_BASE : MSWI_BASE);
        return r == REG_MTIMECMP ? 13'(d >> 3) : (r == REG_MSIP || r == REG_SSIP) ? 13'(d >> 2) : 13'd0;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] ws);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = ws[i] ? wd[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/axi4lite_if.sv
// axi4lite_if: AXI4-lite bundle; target_port faces a register block, initiator_port faces a master
interface axi4lite_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic [AWIDTH-1:0]   awaddr;
    logic                awvalid, awready;
    logic [DWIDTH-1:0]   wdata;
    logic [DWIDTH/8-1:0] wstrb;
    logic                wvalid, wready;
    logic [1:0]          bresp;
    logic                bvalid, bready;
    logic [AWIDTH-1:0]   araddr;
    logic                arvalid, arready;
    logic [DWIDTH-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid, rready;

    modport target_port (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport initiator_port (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/aclint_tick_gen.sv
// aclint_tick_gen: mtime prescaler; tick pulses once every div+1 cycles
// Ports: clk, rst (sync, active-high), div (terminal count), div_wr (restart count), tick (increment strobe)
module aclint_tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] div,
    input  logic        div_wr,
    output logic        tick
);
    logic [31:0] cnt;

    // A divider write restarts the period, so no tick is issued in that cycle.
    assign tick = !div_wr && cnt == div;

    always_ff @(posedge clk)
        if (rst || div_wr) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 32'd1;
endmodule

// File: rtl/aclint.sv
// aclint: MSWI/SSWI/MTIMER block for NUM_HARTS harts behind one AXI4-lite target port
// Ports: clk, rst (sync, active-high); msip/ssip/mtip per-hart interrupts; mtime_o broadcast time;
//        axi_if register access (32/64-bit data bus)
module aclint
    import aclint_pkg::*;
#(
    parameter int          AWIDTH    = 32,
    parameter int          DWIDTH    = 32,
    parameter int          NUM_HARTS = 1,
    parameter logic [31:0] DIV_RESET = 32'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [NUM_HARTS-1:0] msip,
    output logic [NUM_HARTS-1:0] ssip,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [63:0]          mtime_o,
    axi4lite_if.target_port      axi_if
);
    localparam int HW = NUM_HARTS > 1 ? $clog2(NUM_HARTS) : 1;

    if (DWIDTH != 32 && DWIDTH != 64) begin : g_bad_dwidth
        $error("aclint: DWIDTH must be 32 or 64");
    end
    if (NUM_HARTS < 1 || NUM_HARTS > 64 || AWIDTH < 16) begin : g_bad_cfg
        $error("aclint: NUM_HARTS must be 1..64 and AWIDTH at least 16");
    end

    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_ACC, WR_RESP} wr_state_e;

    rd_state_e   rd_st;
    wr_state_e   wr_st;
    logic [63:0] mtime, mtime_inc, mtime_nx, div_m, wd, w64d, rval, rd64;
    logic [63:0] mtimecmp [NUM_HARTS];
    logic [31:0] div, w32d;
    logic [15:0] woff, roff;
    logic [12:0] whart, rhart;
    logic [HW-1:0] ridx;
    logic [7:0]  ws, w64s;
    logic [3:0]  w32s;
    region_e     wreg, rreg;
    logic        tick, wfire, wok, werr, rerr, div_wr, ris64, unused_ok;

    assign woff  = axi_if.awaddr[15:0];
    assign roff  = axi_if.araddr[15:0];
    assign wreg  = region_of(woff);
    assign rreg  = region_of(roff);
    assign whart = hart_of(woff, wreg);
    assign rhart = hart_of(roff, rreg);
    assign werr  = wreg == REG_NONE || 32'(whart) >= NUM_HARTS;
    assign rerr  = rreg == REG_NONE || 32'(rhart) >= NUM_HARTS;
    assign ridx  = HW'(rhart);

    // Normalise the bus into a 64-bit register view: 32-bit registers take the lane picked by
    // addr[2] on a 64-bit bus, 64-bit registers take the half picked by addr[2] on a 32-bit bus.
    assign wd   = 64'(axi_if.wdata);
    assign ws   = 8'(axi_if.wstrb);
    assign w32d = DWIDTH == 64 && woff[2] ? wd[63:32] : wd[31:0];
    assign w32s = DWIDTH == 64 && woff[2] ? ws[7:4] : ws[3:0];
    assign w64d = DWIDTH == 32 && woff[2] ? {wd[31:0], 32'd0} : wd;
    assign w64s = DWIDTH == 32 && woff[2] ? {ws[3:0], 4'd0} : ws;

    assign wfire  = wr_st == WR_ACC && axi_if.awvalid && axi_if.wvalid;
    assign wok    = wfire && !werr;
    assign div_wr = wok && wreg == REG_DIV;
    assign div_m  = merge({32'd0, div}, {32'd0, w32d}, {4'd0, w32s});

    // Written bytes override the tick-incremented value byte by byte, so no carry crosses into them.
    assign mtime_inc = mtime + 64'(tick);
    assign mtime_nx  = wok && wreg == REG_MTIME ? merge(mtime_inc, w64d, w64s) : mtime_inc;
    assign mtime_o   = mtime;

    assign rval  = rreg == REG_MSIP     ? 64'(msip[ridx]) :
                   rreg == REG_SSIP     ? 64'(ssip[ridx]) :
                   rreg == REG_MTIMECMP ? mtimecmp[ridx] :
                   rreg == REG_MTIME    ? mtime :
                   rreg == REG_DIV      ? 64'(div) : '0;
    assign ris64 = rreg == REG_MTIMECMP || rreg == REG_MTIME;
    assign rd64  = rerr ? '0 :
                   DWIDTH == 32 ? (ris64 && roff[2] ? {32'd0, rval[63:32]} : rval) :
                                  (!ris64 && roff[2] ? {rval[31:0], 32'd0} : rval);

    assign unused_ok = ^{axi_if.awaddr, axi_if.araddr, div_m[63:32]};

    aclint_tick_gen u_tick (
        .clk    (clk),
        .rst    (rst),
        .div    (div),
        .div_wr (div_wr),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= '0;
            div   <= DIV_RESET;
            msip  <= '0;
            ssip  <= '0;
            mtip  <= '0;
            for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
        end else begin
            mtime <= mtime_nx;
            if (div_wr) div <= div_m[31:0];
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtip[h] <= mtime >= mtimecmp[h];
                if (wok && whart == 13'(h)) begin
                    if (wreg == REG_MSIP && w32s[0]) msip[h] <= w32d[0];
                    if (wreg == REG_SSIP && w32s[0]) ssip[h] <= w32d[0];
                    if (wreg == REG_MTIMECMP) mtimecmp[h] <= merge(mtimecmp[h], w64d, w64s);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_st          <= RD_IDLE;
            axi_if.arready <= 1'b0;
            axi_if.rvalid  <= 1'b0;
            axi_if.rdata   <= '0;
            axi_if.rresp   <= AXI_OKAY;
        end else if (rd_st == RD_IDLE) begin
            axi_if.arready <= !(axi_if.arready && axi_if.arvalid);
            if (axi_if.arready && axi_if.arvalid) begin
                rd_st         <= RD_RESP;
                axi_if.rvalid <= 1'b1;
                axi_if.rdata  <= DWIDTH'(rd64);
                axi_if.rresp  <= rerr ? AXI_SLVERR : AXI_OKAY;
            end
        end else if (axi_if.rready) begin
            rd_st          <= RD_IDLE;
            axi_if.rvalid  <= 1'b0;
            axi_if.arready <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_st          <= WR_IDLE;
            axi_if.awready <= 1'b0;
            axi_if.wready  <= 1'b0;
            axi_if.bvalid  <= 1'b0;
            axi_if.bresp   <= AXI_OKAY;
        end else begin
            case (wr_st)
                WR_IDLE: if (axi_if.awvalid && axi_if.wvalid) begin
                    wr_st          <= WR_ACC;
                    axi_if.awready <= 1'b1;
                    axi_if.wready  <= 1'b1;
                end
                WR_ACC: begin
                    wr_st          <= wfire ? WR_RESP : WR_IDLE;
                    axi_if.awready <= 1'b0;
                    axi_if.wready  <= 1'b0;
                    axi_if.bvalid  <= wfire;
                    axi_if.bresp   <= werr ? AXI_SLVERR : AXI_OKAY;
                end
                default: if (axi_if.bready) begin
                    wr_st         <= WR_IDLE;
                    axi_if.bvalid <= 1'b0;
                end
            endcase
        end
    end
endmodule
